muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide engine for MULT/MULTU/DIV/DIVU (op=000000, func 011000..011011).
//  Sits beside the EX stage and produces the paired Hi/Lo write into the register file:
//  we_hi_lo, hi_result (-> Di) and lo_result (-> Result_next_wr).
//  Holds busy high so the hazard logic stalls MFHI/MFLO and further mul/div issue until the write lands.
// PARAMETERS
//  DATA_W   32   operand width. hi_result/lo_result are DATA_W each.
//  CNT_W    6    iteration counter width. Must satisfy 2**CNT_W > DATA_W.
// PORTS
//  clk        in   1       rising-edge clock. Single clock domain.
//  rst        in   1       synchronous, active-high reset.
//  start      in   1       issue request. Sampled only in IDLE.
//  func       in   6       011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU. Other values: start ignored.
//  src_a      in   DATA_W  rs operand (multiplicand / dividend).
//  src_b      in   DATA_W  rt operand (multiplier / divisor).
//  flush      in   1       abort in-flight op (syscall/eret redirect).
//  busy       out  1       high whenever state != IDLE.
//  we_hi_lo   out  1       one-cycle write strobe into Hi/Lo.
//  hi_result  out  DATA_W  product[2W-1:W] / remainder.
//  lo_result  out  DATA_W  product[W-1:0] / quotient.
// BEHAVIOUR
//  Reset:
//   - state=IDLE; busy=0, we_hi_lo=0, hi_result=0, lo_result=0.
//   - Reset mid-operation discards the op with no write.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  IDLE:
//   - start && legal func: latch |operands| for signed ops, record the result signs, load counter=DATA_W-1, go to CALC.
//  CALC: one radix-2 step per cycle, DATA_W cycles total.
//   - Multiply: shift-add into a 2*DATA_W accumulator.
//   - Divide: restoring shift-subtract.
//   - Counter==0 -> FIX.
//  FIX: apply signs.
//   - Product: negate if sign(a)^sign(b).
//   - Quotient: truncate toward zero.
//   - Remainder: takes the sign of the dividend.
//   - Register the results, go to DONE.
//  DONE: we_hi_lo=1 for exactly this cycle, next state IDLE.
//  Latency and issue:
//   - Start sampled at edge 0; we_hi_lo is high during cycle DATA_W+2 (34 by default).
//   - busy is high from cycle 1 through cycle DATA_W+2 inclusive.
//   - start while busy (including DONE) is ignored. The issuer must stall.
//  hi_result/lo_result hold their last values after DONE until the next FIX.
//  Divide by zero (DIV and DIVU): no trap; lo=all ones, hi=src_a.
//  Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
//  flush: in any non-IDLE state, next state is IDLE with no we_hi_lo.
//   - A flush in DONE still suppresses the strobe: the output is we_hi_lo = (state==DONE) & ~flush.
//   - flush and start in the same IDLE cycle: flush wins and the op is not accepted.
// CONFIGURATION
//  MULDIV_FAST_MULT_EN:
//   - Defined: MULT/MULTU skip CALC. IDLE -> FIX computes the product with a single-cycle array multiply,
//     so we_hi_lo is high in cycle 2.
//   - Divides are unchanged.
//   - Undefined: all ops are iterative, as above.
// STRUCTURE
//  Package muldiv_pkg: func encodings (FN_MULT, FN_MULTU, FN_DIV, FN_DIVU), state enum, DIV0 result constants.
//  Sub-module muldiv_sign_fix: combinational abs/negate helper, used at the operand latch and in FIX.
// TESTING
//  - MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; strobe in cycle 34.
//  - MULT 0xFFFFFFFE(-2) * 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  - DIV 0xFFFFFFF9(-7) / 2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//    DIVU 7/2 -> lo=3, hi=1.
//  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
//    DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  - flush at cycle 10, then at the DONE cycle -> no we_hi_lo in either run; busy=0 next cycle.
//    start while busy -> ignored, and the first result is unchanged.
//  - rst at cycle 5 -> no strobe, all outputs 0.
//    With MULDIV_FAST_MULT_EN: MULT 6*7 -> lo=42 with the strobe in cycle 2.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - function-field encodings of MULT/MULTU/DIV/DIVU
//   - the controller state enumeration
//   - the fixed results written for a divide by zero
//   - a helper that tells whether a func value names a mul/div op
// No ports (package).
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // Divide by zero does not trap: Lo is filled with this bit (all ones)
    // and Hi receives the untouched dividend.
    localparam logic DIV0_LO_FILL      = 1'b1;
    localparam logic DIV0_HI_IS_SRC_A  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The four legal encodings share the upper four bits 0110.
    function automatic logic isMulDivFunc(input logic [5:0] fn);
        return (fn[5:2] == 4'b0110);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// ---------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational conditional two's-complement negate. Used both to take the
// magnitude of signed operands when an op is latched and to re-apply the
// result signs in the FIX state.
// Ports:
//   i_value   [WIDTH-1:0]  value to pass through or negate
//   i_negate               1 = output the two's-complement negation
//   o_value   [WIDTH-1:0]  result
// ---------------------------------------------------------------------------
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    // Negating the most negative value yields itself, which is exactly the
    // magnitude we need when it is then treated as unsigned.
    assign o_value = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide engine for MULT/MULTU/DIV/DIVU. Operands are
// latched as magnitudes, a radix-2 shift-add (multiply) or restoring
// shift-subtract (divide) runs for DATA_W cycles, the signs are applied in
// FIX, and DONE raises a one-cycle Hi/Lo write strobe.
//   IDLE -> CALC -> FIX -> DONE -> IDLE
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      issue request, sampled only in IDLE
//   func[5:0]  operation select (MULT/MULTU/DIV/DIVU, others ignored)
//   src_a      rs operand (multiplicand / dividend)
//   src_b      rt operand (multiplier / divisor)
//   flush      abort any in-flight op, blocks a same-cycle start
//   busy       high whenever the controller is not IDLE
//   we_hi_lo   one-cycle Hi/Lo write strobe
//   hi_result  product high half / remainder
//   lo_result  product low half / quotient
// Configuration macro:
//   MULDIV_FAST_MULT_EN  when defined, MULT/MULTU bypass CALC and FIX forms
//                        the product with a single-cycle array multiplier.
// ---------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        func,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              busy,
    output logic              we_hi_lo,
    output logic [DATA_W-1:0] hi_result,
    output logic [DATA_W-1:0] lo_result
);

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_opA;
    logic [DATA_W-1:0]   r_opB;
    logic [DATA_W-1:0]   r_rawA;
    logic [2*DATA_W-1:0] r_acc;
    logic                r_isDiv;
    logic                r_negProd;
    logic                r_negRem;
    logic                r_divZero;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_isSigned;
    logic                w_funcIsDiv;
    logic                w_accept;
    logic                w_weHiLo;
    logic [DATA_W-1:0]   w_absA;
    logic [DATA_W-1:0]   w_absB;
    logic [DATA_W:0]     w_addSum;
    logic [2*DATA_W-1:0] w_mulNext;
    logic [DATA_W:0]     w_remShift;
    logic [DATA_W:0]     w_trial;
    logic [2*DATA_W-1:0] w_divNext;
    logic [2*DATA_W-1:0] w_prodMag;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;

    // Decode of the issue request; flush in the same cycle always wins.
    assign w_isSigned  = (func == FN_MULT) || (func == FN_DIV);
    assign w_funcIsDiv = (func == FN_DIV)  || (func == FN_DIVU);
    assign w_accept    = (r_state == ST_IDLE) && start && isMulDivFunc(func) && !flush;

    // Operand magnitudes for the iteration; signs are restored in FIX.
    muldiv_sign_fix #(.WIDTH(DATA_W)) u_absA (
        .i_value  (src_a),
        .i_negate (w_isSigned & src_a[DATA_W-1]),
        .o_value  (w_absA)
    );

    muldiv_sign_fix #(.WIDTH(DATA_W)) u_absB (
        .i_value  (src_b),
        .i_negate (w_isSigned & src_b[DATA_W-1]),
        .o_value  (w_absB)
    );

    // Multiply step: accumulator is {partial product, remaining multiplier}.
    // Add the multiplicand into the top half when the multiplier LSB is set,
    // then shift the whole thing right, keeping the carry.
    assign w_addSum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_opA};
    assign w_mulNext = r_acc[0] ? {w_addSum, r_acc[DATA_W-1:1]}
                                : {1'b0, r_acc[2*DATA_W-1:1]};

    // Divide step: accumulator is {partial remainder, dividend/quotient}.
    // Shift left, trial-subtract the divisor, keep the result if it did not
    // borrow and shift a 1 into the quotient.
    assign w_remShift = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_trial    = w_remShift - {1'b0, r_opB};
    assign w_divNext  = w_trial[DATA_W] ? {r_acc[2*DATA_W-2:0], 1'b0}
                                        : {w_trial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};

`ifdef MULDIV_FAST_MULT_EN
    assign w_prodMag = {{DATA_W{1'b0}}, r_opA} * {{DATA_W{1'b0}}, r_opB};
`else
    assign w_prodMag = r_acc;
`endif

    // Sign application: quotient shares the product sign, the remainder
    // follows the dividend.
    muldiv_sign_fix #(.WIDTH(2*DATA_W)) u_negProd (
        .i_value  (w_prodMag),
        .i_negate (r_negProd),
        .o_value  (w_prod)
    );

    muldiv_sign_fix #(.WIDTH(DATA_W)) u_negQuot (
        .i_value  (r_acc[DATA_W-1:0]),
        .i_negate (r_negProd),
        .o_value  (w_quot)
    );

    muldiv_sign_fix #(.WIDTH(DATA_W)) u_negRem (
        .i_value  (r_acc[2*DATA_W-1:DATA_W]),
        .i_negate (r_negRem),
        .o_value  (w_rem)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe. A flush anywhere outside IDLE returns to IDLE
    // and also masks the strobe if it lands in DONE.
    always_comb begin
        w_next   = r_state;
        w_weHiLo = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
`ifdef MULDIV_FAST_MULT_EN
                    w_next = w_funcIsDiv ? ST_CALC : ST_FIX;
`else
                    w_next = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (r_cnt == '0) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next   = ST_IDLE;
                w_weHiLo = ~flush;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (flush && (r_state != ST_IDLE)) begin
            w_next = ST_IDLE;
        end
    end

    // Datapath: operand latch in IDLE, one iteration per CALC cycle, and the
    // signed results registered in FIX (skipped when the op is being flushed).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_rawA    <= '0;
            r_acc     <= '0;
            r_isDiv   <= 1'b0;
            r_negProd <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_opA     <= w_absA;
                        r_opB     <= w_absB;
                        r_rawA    <= src_a;
                        r_isDiv   <= w_funcIsDiv;
                        r_negProd <= w_isSigned & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                        r_negRem  <= w_isSigned & src_a[DATA_W-1];
                        r_divZero <= (src_b == '0);
                        r_cnt     <= CNT_W'(DATA_W - 1);
                        r_acc     <= w_funcIsDiv ? {{DATA_W{1'b0}}, w_absA}
                                                 : {{DATA_W{1'b0}}, w_absB};
                    end
                end
                ST_CALC: begin
                    r_acc <= r_isDiv ? w_divNext : w_mulNext;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_FIX: begin
                    if (!flush) begin
                        if (r_isDiv && r_divZero) begin
                            r_hi <= DIV0_HI_IS_SRC_A ? r_rawA : '0;
                            r_lo <= {DATA_W{DIV0_LO_FILL}};
                        end else if (r_isDiv) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod[2*DATA_W-1:DATA_W];
                            r_lo <= w_prod[DATA_W-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign we_hi_lo  = w_weHiLo;
    assign hi_result = r_hi;
    assign lo_result = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (DATA_W=32). Expected Hi/Lo values come
// from plain 64-bit arithmetic on the operands; expected timing comes from the
// documented latency (34 cycles, or 2 for multiplies with
// MULDIV_FAST_MULT_EN). Cycle 0 is the cycle in which start is sampled.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam logic [5:0] T_MULT  = 6'b011000;
    localparam logic [5:0] T_MULTU = 6'b011001;
    localparam logic [5:0] T_DIV   = 6'b011010;
    localparam logic [5:0] T_DIVU  = 6'b011011;
    localparam int MAX_CYC = 45;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  func;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        we_hi_lo;
    logic [31:0] hi_result;
    logic [31:0] lo_result;

    int testsRun;
    int testsFailed;

    muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .func      (func),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .we_hi_lo  (we_hi_lo),
        .hi_result (hi_result),
        .lo_result (lo_result)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: results straight from integer arithmetic.
    function automatic void refModel(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint sa;
        longint sb;
        logic [63:0] p;
        int ia;
        int ib;
        hi = '0;
        lo = '0;
        case (f)
            T_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            T_MULTU: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            T_DIV: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFFFFFF;
                    hi = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    lo = 32'h80000000;
                    hi = 32'd0;
                end else begin
                    ia = int'(a);
                    ib = int'(b);
                    lo = 32'(ia / ib);
                    hi = 32'(ia % ib);
                end
            end
            T_DIVU: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFFFFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: begin
            end
        endcase
    endfunction

    function automatic int latFor(input logic [5:0] f);
`ifdef MULDIV_FAST_MULT_EN
        if (f == T_MULT || f == T_MULTU) return 2;
`endif
        return 34;
    endfunction

    // Drives one issue and watches the unit for MAX_CYC cycles.
    // flushAt/rstAt/startAt < 0 mean "not used"; startAt injects a second
    // (DIV) request while the first should still be busy. busy is expected
    // high for cycles 1..endCyc where endCyc is the abort cycle or expLat.
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input int expLat, input int flushAt, input int rstAt, input int startAt,
                                 output logic [31:0] hiObs, output logic [31:0] loObs,
                                 output int strobeCycle, output int strobeCount, output int busyErr);
        int endCyc;
        endCyc = expLat;
        if (flushAt >= 0) endCyc = flushAt;
        else if (rstAt >= 0) endCyc = rstAt;
        strobeCycle = -1;
        strobeCount = 0;
        busyErr     = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        func  = f;
        src_a = a;
        src_b = b;
        flush = (flushAt == 0);
        rst   = (rstAt == 0);
        @(posedge clk);
        #1;
        for (int c = 1; c <= MAX_CYC; c++) begin
            flush = (c == flushAt);
            rst   = (c == rstAt);
            if (c == startAt) begin
                start = 1'b1;
                func  = T_DIV;
                src_a = $urandom;
                src_b = $urandom;
            end else begin
                start = 1'b0;
            end
            #1;
            if (we_hi_lo === 1'b1) begin
                strobeCount++;
                if (strobeCycle < 0) strobeCycle = c;
            end
            if (busy !== (c <= endCyc)) busyErr++;
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        flush  = 1'b0;
        rst    = 1'b0;
        hiObs  = hi_result;
        loObs  = lo_result;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        func  = 6'd0;
        src_a = '0;
        src_b = '0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy: got %b want 0", busy);
        end
        testsRun++;
        if (we_hi_lo !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_we: got %b want 0", we_hi_lo);
        end
        testsRun++;
        if (hi_result !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_hi: got %h want 0", hi_result);
        end
        testsRun++;
        if (lo_result !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_lo: got %h want 0", lo_result);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [5:0]  fv [6];
        logic [31:0] av [6];
        logic [31:0] bv [6];
        logic [31:0] hiObs, loObs, hiExp, loExp;
        int sc, sn, be;
        fv = '{T_MULTU, T_MULT, T_DIV, T_DIVU, T_DIVU, T_DIV};
        av = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd7, 32'd5, 32'h80000000};
        bv = '{32'hFFFFFFFF, 32'd3, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
        for (int i = 0; i < 6; i++) begin
            refModel(fv[i], av[i], bv[i], hiExp, loExp);
            applyStimulus(fv[i], av[i], bv[i], latFor(fv[i]), -1, -1, -1, hiObs, loObs, sc, sn, be);
            testsRun++;
            if (hiObs !== hiExp) begin
                testsFailed++;
                $display("[TB] FAIL directed%0d_hi: got %h want %h", i, hiObs, hiExp);
            end
            testsRun++;
            if (loObs !== loExp) begin
                testsFailed++;
                $display("[TB] FAIL directed%0d_lo: got %h want %h", i, loObs, loExp);
            end
            testsRun++;
            if (sn !== 1 || sc !== latFor(fv[i])) begin
                testsFailed++;
                $display("[TB] FAIL directed%0d_strobe: got %0d strobes first at %0d want 1 at %0d",
                         i, sn, sc, latFor(fv[i]));
            end
            testsRun++;
            if (be !== 0) begin
                testsFailed++;
                $display("[TB] FAIL directed%0d_busy: got %0d bad busy cycles want 0", i, be);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0]  f;
        logic [31:0] a, b, hiObs, loObs, hiExp, loExp;
        int sc, sn, be;
        for (int i = 0; i < 24; i++) begin
            f = 6'b011000 | 6'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9)) - 32'd4;
            if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 20));
            refModel(f, a, b, hiExp, loExp);
            applyStimulus(f, a, b, latFor(f), -1, -1, -1, hiObs, loObs, sc, sn, be);
            testsRun++;
            if (hiObs !== hiExp || loObs !== loExp) begin
                testsFailed++;
                $display("[TB] FAIL random%0d f=%b a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h",
                         i, f, a, b, hiObs, loObs, hiExp, loExp);
            end
            testsRun++;
            if (sn !== 1 || sc !== latFor(f) || be !== 0) begin
                testsFailed++;
                $display("[TB] FAIL random%0d_timing: got %0d strobes at %0d, %0d bad busy; want 1 at %0d, 0",
                         i, sn, sc, be, latFor(f));
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] hiObs, loObs, hiExp, loExp;
        int sc, sn, be;
        // Establish known Hi/Lo first.
        refModel(T_DIVU, 32'd100, 32'd7, hiExp, loExp);
        applyStimulus(T_DIVU, 32'd100, 32'd7, 34, -1, -1, -1, hiObs, loObs, sc, sn, be);
        // Flush mid-iteration: no strobe, Hi/Lo untouched.
        applyStimulus(T_DIVU, 32'hDEADBEEF, 32'd3, 34, 10, -1, -1, hiObs, loObs, sc, sn, be);
        testsRun++;
        if (sn !== 0 || be !== 0) begin
            testsFailed++;
            $display("[TB] FAIL flush_mid: got %0d strobes %0d bad busy want 0 0", sn, be);
        end
        testsRun++;
        if (hiObs !== hiExp || loObs !== loExp) begin
            testsFailed++;
            $display("[TB] FAIL flush_mid_hold: got %h/%h want %h/%h", hiObs, loObs, hiExp, loExp);
        end
        // Flush in the DONE cycle suppresses the strobe.
        applyStimulus(T_MULT, 32'd9, 32'd11, latFor(T_MULT), latFor(T_MULT), -1, -1, hiObs, loObs, sc, sn, be);
        testsRun++;
        if (sn !== 0 || be !== 0) begin
            testsFailed++;
            $display("[TB] FAIL flush_done: got %0d strobes %0d bad busy want 0 0", sn, be);
        end
        // Flush together with start: op never accepted.
        applyStimulus(T_DIV, 32'd50, 32'd5, 34, 0, -1, -1, hiObs, loObs, sc, sn, be);
        testsRun++;
        if (sn !== 0 || be !== 0) begin
            testsFailed++;
            $display("[TB] FAIL flush_start: got %0d strobes %0d bad busy want 0 0", sn, be);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] hiObs, loObs, hiExp, loExp;
        int sc, sn, be;
        int injectAt [2];
        injectAt = '{5, 34};
        for (int i = 0; i < 2; i++) begin
            refModel(T_DIVU, 32'h12345678, 32'd1000 + 32'(i), hiExp, loExp);
            applyStimulus(T_DIVU, 32'h12345678, 32'd1000 + 32'(i), 34, -1, -1, injectAt[i],
                          hiObs, loObs, sc, sn, be);
            testsRun++;
            if (hiObs !== hiExp || loObs !== loExp) begin
                testsFailed++;
                $display("[TB] FAIL busy_start%0d_result: got %h/%h want %h/%h", i, hiObs, loObs, hiExp, loExp);
            end
            testsRun++;
            if (sn !== 1 || sc !== 34 || be !== 0) begin
                testsFailed++;
                $display("[TB] FAIL busy_start%0d_timing: got %0d strobes at %0d, %0d bad busy; want 1 at 34, 0",
                         i, sn, sc, be);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] hiObs, loObs;
        int sc, sn, be;
        applyStimulus(6'b100000, 32'd6, 32'd7, 0, -1, -1, -1, hiObs, loObs, sc, sn, be);
        testsRun++;
        if (sn !== 0 || be !== 0) begin
            testsFailed++;
            $display("[TB] FAIL illegal_func: got %0d strobes %0d bad busy want 0 0", sn, be);
        end
    endtask

    task automatic checkOutput();
        logic [31:0] hiObs, loObs;
        int sc, sn, be;
        // Leave non-zero results behind, then reset in cycle 5 of a new op.
        applyStimulus(T_MULTU, 32'd6, 32'd7, latFor(T_MULTU), -1, -1, -1, hiObs, loObs, sc, sn, be);
        testsRun++;
        if (loObs !== 32'd42 || hiObs !== 32'd0 || sc !== latFor(T_MULTU)) begin
            testsFailed++;
            $display("[TB] FAIL mult6x7: got hi=%h lo=%h at %0d want 0/2a at %0d", hiObs, loObs, sc, latFor(T_MULTU));
        end
        applyStimulus(T_DIVU, 32'd77, 32'd5, 34, -1, 5, -1, hiObs, loObs, sc, sn, be);
        testsRun++;
        if (sn !== 0 || be !== 0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_timing: got %0d strobes %0d bad busy want 0 0", sn, be);
        end
        testsRun++;
        if (hiObs !== 32'd0 || loObs !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_outputs: got %h/%h want 0/0", hiObs, loObs);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_illegal();
        checkOutput();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
